// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the 3-stage pipeline sequencer.
//   - FSM state encoding (2-bit; code 2'd3 is unused and recovers to RUN)
//   - NOP control-field constants loaded into Dec/Exe on a bubble
//   - multiplier latency counter width and default latency
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StBrExe = 2'd1,
        StBrWb  = 2'd2
    } seq_state_e;

    // Control fields of the Dec/Exe buffer that a bubble must clear.
    typedef struct packed {
        logic has_wb;
        logic is_jump;
        logic is_mult;
    } dec_exe_ctrl_t;

    localparam dec_exe_ctrl_t NopCtrl = '{has_wb: 1'b0, is_jump: 1'b0, is_mult: 1'b0};

    localparam int unsigned McntW          = 4;
    localparam int unsigned DefaultMultLat = 2;

endpackage

// File: rtl/mult_latency_counter.sv
// mult_latency_counter: tracks how long the multiplier result is still pending.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (clears the count)
//   load_i      multiplier launched this cycle; load load_val_i
//   load_val_i  latency in cycles
//   busy_o      result not yet valid (count nonzero)
module mult_latency_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             busy_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: central sequencing FSM for the Decode/Execute/Writeback
// 16-bit pipeline. Generates PC, Dec/Exe, Exe/WB and register-bank enables,
// stalls decode behind branches until they resolve in Writeback, interlocks
// Hi/Lo readers and new multiplies behind a busy multiplier, and counts stalls.
// Ports:
//   CLK, RST                 clock; synchronous active-high reset
//   dec_is_branch            Decode holds a jump/branch
//   dec_is_mult              Decode holds a multiply
//   dec_use_hilo             Decode reads Hi/Lo
//   wb_taken                 branch in Exe/WB resolved taken (used in BR_WB only)
//   pc_wr, pc_sel_jmp        PC write enable / select external target
//   dec_exe_wr               load Dec/Exe from decoder
//   dec_exe_bubble           load NOP into Dec/Exe
//   exe_wb_wr, reg_bank_wr   Exe/WB write enable / register-bank write permission
//   mult_start, mult_busy    launch pulse / multiplier result pending
//   stall_cnt                saturating count of cycles with pc_wr=0
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = DefaultMultLat,
    parameter int unsigned STALL_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               dec_is_branch,
    input  logic               dec_is_mult,
    input  logic               dec_use_hilo,
    input  logic               wb_taken,
    output logic               pc_wr,
    output logic               pc_sel_jmp,
    output logic               dec_exe_wr,
    output logic               dec_exe_bubble,
    output logic               exe_wb_wr,
    output logic               reg_bank_wr,
    output logic               mult_start,
    output logic               mult_busy,
    output logic [STALL_W-1:0] stall_cnt
);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;
    logic               busy;
    logic               ilk;

    mult_latency_counter #(
        .Width(McntW)
    ) u_mcnt (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (mult_start),
        .load_val_i(McntW'(MULT_LAT)),
        .busy_o    (busy)
    );

    // One multiplier: a new multiply or a Hi/Lo read must wait for the result.
    assign ilk = (dec_use_hilo | dec_is_mult) & busy;

    always_comb begin
        state_d        = state_q;
        pc_wr          = 1'b0;
        pc_sel_jmp     = 1'b0;
        dec_exe_wr     = 1'b0;
        dec_exe_bubble = 1'b0;
        exe_wb_wr      = 1'b0;
        reg_bank_wr    = 1'b0;
        mult_start     = 1'b0;

        case (state_q)
            StRun: begin
                exe_wb_wr   = 1'b1;
                reg_bank_wr = 1'b1;
                // Interlock wins over a branch; the branch waits in Decode.
                if (ilk) begin
                    dec_exe_bubble = 1'b1;
                end else begin
                    pc_wr      = 1'b1;
                    dec_exe_wr = 1'b1;
                    mult_start = dec_is_mult;
                    if (dec_is_branch) begin
                        state_d = StBrExe;
                    end
                end
            end
            StBrExe: begin
                // Decode holds a wrong-path fetch; squash it.
                dec_exe_bubble = 1'b1;
                exe_wb_wr      = 1'b1;
                reg_bank_wr    = 1'b1;
                state_d        = StBrWb;
            end
            StBrWb: begin
                pc_wr          = 1'b1;
                pc_sel_jmp     = wb_taken;
                dec_exe_bubble = 1'b1;
                exe_wb_wr      = 1'b1;
                reg_bank_wr    = 1'b1;
                state_d        = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (RST) begin
            pc_wr          = 1'b0;
            pc_sel_jmp     = 1'b0;
            dec_exe_wr     = 1'b0;
            dec_exe_bubble = 1'b0;
            exe_wb_wr      = 1'b0;
            reg_bank_wr    = 1'b0;
            mult_start     = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_wr && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StRun;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign mult_busy = busy & ~RST;
    assign stall_cnt = RST ? '0 : stall_q;

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central sequencing controller for the 3-stage (Decode / Execute / Writeback) 16-bit pipeline. It generates every pipeline-register and PC write enable from a single FSM.
- Control hazards: branches and jumps stall decode until they resolve in Writeback.
- Structural and data hazards: the multi-cycle multiplier is handled by an internal latency counter.
- Statistics: a saturating stall-cycle counter is exposed.

It sits beside the datapath top level and drives the PC register, the Dec/Exe buffer, the Exe/WB buffer and the register-bank write port.

## Interface
Parameters:
- MULT_LAT, default 2: cycles from `mult_start` until Hi/Lo are valid (legal range 1..15).
- STALL_W, default 16: width of the stall statistics counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- dec_is_branch  in  1  the instruction in Decode is a jump or branch (the decoder's hasStall).
- dec_is_mult  in  1  the instruction in Decode starts a multiply.
- dec_use_hilo  in  1  the instruction in Decode reads Hi/Lo.
- wb_taken  in  1  the branch now in the Exe/WB buffer resolved taken; sampled only in state BR_WB.
- pc_wr  out  1  PC register write enable.
- pc_sel_jmp  out  1  PC mux selects the external target; otherwise PC+1.
- dec_exe_wr  out  1  load the Dec/Exe buffer from the decoder.
- dec_exe_bubble  out  1  load a NOP into the Dec/Exe buffer (HasWB=0, IsJump=0, IsMult=0).
- exe_wb_wr  out  1  Exe/WB buffer write enable.
- reg_bank_wr  out  1  register-bank write permission (ANDed with the buffered HasWB).
- mult_start  out  1  one-cycle pulse that launches the multiplier.
- mult_busy  out  1  the multiplier result is not yet valid.
- stall_cnt  out  STALL_W  count of cycles with pc_wr=0, saturating.

## Operation
- There are three FSM states, held in a 2-bit register: RUN, BR_EXE and BR_WB.
- Multiply counter `mcnt`:
  - Width is 4 bits.
  - It is loaded with MULT_LAT when mult_start=1.
  - Otherwise it decrements when nonzero.
  - mult_busy = (mcnt != 0).
- Interlock condition `ilk` = (dec_use_hilo | dec_is_mult) & mult_busy. It covers both the Hi/Lo read-after-write hazard and the single-multiplier structural hazard.
- RUN:
  - exe_wb_wr=1 and reg_bank_wr=1 always.
  - If ilk: pc_wr=0, dec_exe_bubble=1, dec_exe_wr=0; the state stays RUN.
  - Otherwise: pc_wr=1 and dec_exe_wr=1.
    - mult_start = dec_is_mult.
    - If dec_is_branch, go to BR_EXE; else stay in RUN.
  - ilk has priority over dec_is_branch. A branch that is blocked by ilk stays in Decode.
- BR_EXE: the branch is in Execute.
  - pc_wr=0, dec_exe_bubble=1 (the Decode contents are wrong-path).
  - exe_wb_wr=1, reg_bank_wr=1.
  - Next state: BR_WB.
- BR_WB: the branch is in Writeback.
  - pc_wr=1, pc_sel_jmp=wb_taken, dec_exe_bubble=1.
  - exe_wb_wr=1, reg_bank_wr=1.
  - Next state: RUN.
- Output exclusivity: dec_exe_wr and dec_exe_bubble are never both 1, and pc_sel_jmp=1 only in BR_WB.
- Stall counter: stall_cnt increments on every cycle where pc_wr=0. At 2^STALL_W−1 it holds.

## Timing
- All outputs are combinational from (state, mcnt, inputs) and are forced to 0 while RST=1.
- Reset (RST high at an edge), including mid-branch or mid-multiply:
  - state=RUN, mcnt=0, stall_cnt=0.
  - The next cycle behaves as RUN with mult_busy=0.
- A branch accepted at edge N gives: BR_EXE in cycle N+1, BR_WB in cycle N+2, RUN in cycle N+3.
  - Penalty is exactly 2 bubbles.
  - stall_cnt += 1, since only BR_EXE has pc_wr=0.
- Multiply started at edge N: mult_busy=1 for cycles N+1 … N+MULT_LAT, then 0.
  - A Hi/Lo consumer in Decode during those cycles stalls.
  - It issues in the first cycle with mult_busy=0.
- mult_start may pulse only in RUN with ilk=0. A new multiply while busy is interlocked, never restarted.
- wb_taken outside BR_WB has no effect.

## Structure
- A shared package `pipe_ctrl_pkg` holds:
  - the state encoding (RUN=2'd0, BR_EXE=2'd1, BR_WB=2'd2; 2'd3 is illegal and recovers to RUN next cycle);
  - the NOP field constants used for the bubble;
  - the default MULT_LAT.
- One sub-module is natural: `mult_latency_counter` (load, decrement, busy). The FSM and stall counter remain in `pipeline_sequencer`.

## Test plan
- Reset: hold RST 2 cycles with dec_is_branch=1 → all outputs 0. First cycle after reset: pc_wr=1, dec_exe_wr=1, stall_cnt=0.
- Taken branch: dec_is_branch=1 in RUN at cycle 0.
  - Cycle 1: pc_wr=0, bubble=1.
  - Cycle 2 with wb_taken=1: pc_wr=1, pc_sel_jmp=1.
  - Cycle 3: RUN; stall_cnt=1.
- Not-taken branch: same sequence with wb_taken=0 → pc_sel_jmp=0 in BR_WB. wb_taken=1 pulsed in RUN → pc_sel_jmp stays 0.
- Multiply interlock (MULT_LAT=3): dec_is_mult=1, then dec_use_hilo=1 held.
  - mult_start pulses once.
  - pc_wr=0 and bubble=1 for 3 cycles, then pc_wr=1.
  - stall_cnt=3.
- Back-to-back multiply: dec_is_mult=1 on two consecutive cycles → the second waits until mult_busy=0. Exactly two mult_start pulses occur, MULT_LAT+1 cycles apart.
- Priority and saturation:
  - ilk and dec_is_branch together → state stays RUN until ilk clears, then BR_EXE.
  - With STALL_W=2, force 5 stall cycles → stall_cnt=3.
  - RST asserted in BR_EXE → RUN next cycle, mult_busy=0.
